dsp_ram_arbiter: RTL and testbench

Arbitrates the CPU-clock-domain port of the 1024×8 TRS-80 display RAM between three requesters:
- Z80 video writes (single-cycle strobes that must never be lost).
- A clear-screen sequencer that fills the RAM with a fill character.
- A host (ESP) read/write port using a 4-phase req/ack handshake.

It sits between the Z80 bus decode and the display RAM's A port, which remains single-ported on the 100 MHz clock. The video B port on the VGA clock is untouched.

---
 rtl/dsp_ram_arbiter.sv | 97 +++++++++
 tb/tb_dsp_ram_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dsp_ram_arbiter.sv
// dsp_ram_arbiter: display RAM port A arbiter (z80 > clear > host); ports: clk/reset, z80_wr/addr/data, clr_start/busy, host req/we/addr/wdata/ack/rdata, z80_wr_seen, registered ram_ce/we/addr/din, ram_dout
module dsp_ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              z80_wr,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [7:0]        z80_data,
    input  logic              clr_start,
    output logic              clr_busy,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic              z80_wr_seen,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_t;
    typedef enum logic [1:0] {H_IDLE, H_WAIT, H_RD, H_ACK} host_t;
    localparam logic [ADDR_W-1:0] LAST = '1;
    clr_t clr_st, clr_nx;
    host_t h_st, h_nx;
    logic z80_pend, g_z, g_c, g_h, g_any, rd_fresh;
    logic [ADDR_W-1:0] z80_a, cnt, cnt_nx;
    logic [7:0] z80_d, rdata_q;
    always_comb begin
        g_z = z80_pend;
        g_c = !z80_pend && clr_st == CLR_RUN;
        g_h = !z80_pend && clr_st != CLR_RUN && h_st == H_WAIT;
        g_any = g_z || g_c || g_h;
        clr_nx = clr_st;
        cnt_nx = cnt;
        if (clr_st == CLR_IDLE && clr_start) begin
            clr_nx = CLR_RUN;
            cnt_nx = '0;
        end else if (g_c) begin
            clr_nx = cnt == LAST ? CLR_IDLE : CLR_RUN;
            cnt_nx = cnt == LAST ? cnt : cnt + 1'b1;
        end
        h_nx = h_st;
        case (h_st)
            H_IDLE: h_nx = host_req ? H_WAIT : H_IDLE;
            H_WAIT: h_nx = !g_h ? H_WAIT : host_we ? H_ACK : H_RD;
            H_RD:   h_nx = H_ACK;
            H_ACK:  h_nx = host_req ? H_ACK : H_IDLE;
            default: h_nx = H_IDLE;
        endcase
    end
    // the RAM output is only valid in the first ack cycle, so it is passed
    // straight through then and held from the latch afterwards
    assign host_rdata = rd_fresh ? ram_dout : rdata_q;
    assign host_ack = h_st == H_ACK;
    assign clr_busy = clr_st == CLR_RUN;
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_st <= CLR_IDLE;
            h_st <= H_IDLE;
            cnt <= '0;
            z80_pend <= 1'b0;
            z80_a <= '0;
            z80_d <= '0;
            z80_wr_seen <= 1'b0;
            rd_fresh <= 1'b0;
            rdata_q <= '0;
            ram_ce <= 1'b0;
            ram_we <= 1'b0;
            ram_addr <= '0;
            ram_din <= '0;
        end else begin
            clr_st <= clr_nx;
            h_st <= h_nx;
            cnt <= cnt_nx;
            z80_pend <= z80_wr;
            if (z80_wr) begin
                z80_a <= z80_addr;
                z80_d <= z80_data;
            end
            z80_wr_seen <= z80_wr_seen || z80_wr;
            rd_fresh <= h_st == H_RD;
            if (rd_fresh) rdata_q <= ram_dout;
            ram_ce <= g_any;
            ram_we <= g_z || g_c || (g_h && host_we);
            if (g_any) begin
                ram_addr <= g_z ? z80_a : g_c ? cnt : host_addr;
                ram_din <= g_z ? z80_d : g_c ? FILL_CHAR : host_wdata;
            end
        end
    end
endmodule

// File: tb/tb_dsp_ram_arbiter.sv
// tb_dsp_ram_arbiter: directed self-checking bench for dsp_ram_arbiter with a behavioural 1024x8 RAM on port A
module tb_dsp_ram_arbiter;
    logic clk, reset, z80_wr, clr_start, clr_busy, host_req, host_we, host_ack, z80_wr_seen, ram_ce, ram_we;
    logic [9:0] z80_addr, host_addr, ram_addr;
    logic [7:0] z80_data, host_wdata, host_rdata, ram_din, ram_dout;
    logic [7:0] mem [0:1023];
    int total = 0, bad = 0;
    int nfill, nord, done_off, zseen, lat, rdl;
    logic [7:0] rd, rd2;
    logic ack_hold, ack_after, we_ack;

    dsp_ram_arbiter dut (
        .clk(clk), .reset(reset), .z80_wr(z80_wr), .z80_addr(z80_addr), .z80_data(z80_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .z80_wr_seen(z80_wr_seen), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else ram_dout <= mem[ram_addr];
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // starts a clear in the current cycle and watches ~1100 cycles of port A;
    // a z80 write of 0x99 to 0x010 is injected at offset zoff, a stray clr_start at offset 100
    task automatic run_clear(input int zoff, output int nf, output int no, output int dn, output int zs);
        int ea;
        ea = 0; nf = 0; no = 0; dn = -1; zs = -1;
        clr_start = 1'b1;
        nxt;
        clr_start = 1'b0;
        for (int off = 1; off < 1100; off++) begin
            if (ram_ce && ram_we) begin
                if (ram_din == 8'h20) begin
                    if (ram_addr != ea[9:0]) no++;
                    ea++;
                    nf++;
                end else if (ram_din == 8'h99 && ram_addr == 10'h010) zs = off;
            end
            if (!clr_busy && dn < 0) dn = off;
            z80_wr = off == zoff;
            z80_addr = 10'h010;
            z80_data = 8'h99;
            clr_start = off == 100;
            nxt;
        end
        z80_wr = 1'b0;
        clr_start = 1'b0;
    endtask

    // full 4-phase host transfer starting in the current cycle, bounded wait for ack
    task automatic host_xfer(input logic we, input logic [9:0] a, input logic [7:0] wd,
                             output int lt, output int rl, output logic [7:0] r, output logic [7:0] r2,
                             output logic wa, output logic ah, output logic af);
        host_we = we; host_addr = a; host_wdata = wd; host_req = 1'b1;
        lt = 0; rl = -1;
        while (!host_ack && lt < 3000) begin
            if (ram_ce && !ram_we && rl < 0) rl = lt;
            nxt;
            lt++;
        end
        r = host_rdata;
        wa = ram_we;
        nxt;
        ah = host_ack;
        r2 = host_rdata;
        host_req = 1'b0;
        nxt;
        af = host_ack;
    endtask

    initial begin
        reset = 1'b1; z80_wr = 1'b0; z80_addr = '0; z80_data = '0; clr_start = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        nxt; nxt; nxt;
        reset = 1'b0;
        chk("rst_ce", ram_ce, 0); chk("rst_we", ram_we, 0); chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0); chk("rst_busy", clr_busy, 0); chk("rst_ack", host_ack, 0);
        chk("rst_rdata", host_rdata, 0); chk("rst_seen", z80_wr_seen, 0);
        nxt; nxt;
        // single z80 write
        z80_wr = 1'b1; z80_addr = 10'h3C0; z80_data = 8'h41;
        nxt;
        z80_wr = 1'b0;
        chk("z1_seen", z80_wr_seen, 1); chk("z1_ce_n1", ram_ce, 0);
        nxt;
        chk("z1_we", ram_we, 1); chk("z1_ce", ram_ce, 1); chk("z1_addr", ram_addr, 10'h3C0); chk("z1_din", ram_din, 8'h41);
        nxt;
        chk("z1_we_n3", ram_we, 0); chk("z1_ce_n3", ram_ce, 0); chk("z1_hold", ram_addr, 10'h3C0);
        // back-to-back z80 writes
        z80_wr = 1'b1; z80_addr = 10'h000; z80_data = 8'h11;
        nxt;
        z80_addr = 10'h001; z80_data = 8'h22;
        nxt;
        z80_wr = 1'b0;
        chk("bb_we0", ram_we, 1); chk("bb_addr0", ram_addr, 10'h000); chk("bb_din0", ram_din, 8'h11);
        nxt;
        chk("bb_we1", ram_we, 1); chk("bb_addr1", ram_addr, 10'h001); chk("bb_din1", ram_din, 8'h22);
        nxt;
        chk("bb_idle", ram_we, 0); chk("bb_mem0", mem[0], 8'h11); chk("bb_mem1", mem[1], 8'h22);
        // idle host write then read back
        host_xfer(1'b1, 10'h055, 8'hA5, lat, rdl, rd, rd2, we_ack, ack_hold, ack_after);
        chk("hw_lat", lat, 2); chk("hw_we_at_ack", we_ack, 1); chk("hw_hold", ack_hold, 1);
        chk("hw_drop", ack_after, 0); chk("hw_mem", mem[10'h055], 8'hA5);
        host_xfer(1'b0, 10'h055, 8'h00, lat, rdl, rd, rd2, we_ack, ack_hold, ack_after);
        chk("hr_lat", lat, 3); chk("hr_rdlat", rdl, 2); chk("hr_data", rd, 8'hA5);
        chk("hr_data_held", rd2, 8'hA5); chk("hr_hold", ack_hold, 1); chk("hr_drop", ack_after, 0);
        // full clear with ignored restart
        nxt;
        run_clear(-1, nfill, nord, done_off, zseen);
        chk("clr_count", nfill, 1024); chk("clr_order", nord, 0); chk("clr_done", done_off, 1025);
        chk("clr_mem3c0", mem[10'h3C0], 8'h20); chk("clr_mem055", mem[10'h055], 8'h20);
        // clear preempted by a z80 write
        run_clear(10, nfill, nord, done_off, zseen);
        chk("pre_count", nfill, 1024); chk("pre_order", nord, 0); chk("pre_done", done_off, 1026);
        chk("pre_zslot", zseen, 12); chk("pre_mem010", mem[10'h010], 8'h20);
        // host write of a marker, then host read requested during a clear
        host_xfer(1'b1, 10'h200, 8'h77, lat, rdl, rd, rd2, we_ack, ack_hold, ack_after);
        clr_start = 1'b1;
        nxt;
        clr_start = 1'b0;
        nxt; nxt; nxt; nxt;
        chk("hc_busy", clr_busy, 1);
        host_xfer(1'b0, 10'h200, 8'h00, lat, rdl, rd, rd2, we_ack, ack_hold, ack_after);
        chk("hc_lat", lat, 1022); chk("hc_rdlat", rdl, 1021); chk("hc_data", rd, 8'h20);
        chk("hc_hold", ack_hold, 1); chk("hc_drop", ack_after, 0);
        // reset in cycle 300 of a clear with a host read pending
        clr_start = 1'b1;
        nxt;
        clr_start = 1'b0;
        for (int c = 1; c < 300; c++) begin
            if (c == 5) begin
                host_we = 1'b0; host_addr = 10'h300; host_req = 1'b1;
            end
            nxt;
        end
        chk("mr_busy_pre", clr_busy, 1); chk("mr_seen_pre", z80_wr_seen, 1);
        reset = 1'b1; host_req = 1'b0;
        nxt;
        reset = 1'b0;
        chk("mr_ce", ram_ce, 0); chk("mr_we", ram_we, 0); chk("mr_addr", ram_addr, 0);
        chk("mr_din", ram_din, 0); chk("mr_busy", clr_busy, 0); chk("mr_ack", host_ack, 0);
        chk("mr_rdata", host_rdata, 0); chk("mr_seen", z80_wr_seen, 0);
        nxt;
        host_xfer(1'b1, 10'h3FF, 8'h5A, lat, rdl, rd, rd2, we_ack, ack_hold, ack_after);
        chk("mr_hw_lat", lat, 2); chk("mr_hw_drop", ack_after, 0);
        host_xfer(1'b0, 10'h3FF, 8'h00, lat, rdl, rd, rd2, we_ack, ack_hold, ack_after);
        chk("mr_hr_lat", lat, 3); chk("mr_hr_data", rd, 8'h5A); chk("mr_hr_drop", ack_after, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
